// File: rtl/rs_stream_syndrome.sv
// rs_stream_syndrome
//
// Streaming Reed-Solomon syndrome stage over GF(2^8). It takes a received
// codeword one byte per valid/ready handshake, highest-degree coefficient
// first, and builds all NSYM = 2*MAX_ERRORS syndromes by Horner evaluation at
// the roots r_j = first_root * generator^j. A single combinational GF
// multiplier is shared over the syndrome index j, so each accepted byte costs
// NSYM update cycles.
//
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   start          one-cycle request, sampled only in IDLE
//   block_length   bytes per codeword (0 means 256)
//   generator      primitive element alpha
//   first_root     alpha^fcr, the root for S_0
//   irreducible    field polynomial (bit 8 set, bits 7:0 are the reduction mask)
//   in_valid/in_data/in_ready   byte stream handshake
//   busy           high in every state except IDLE
//   done           one-cycle pulse, syndromes are final
//   syndromes      S_j at bits [8j+7:8j]
//   all_zero       every S_j is zero; valid from done until the next start

module rs_stream_syndrome #(
    parameter int unsigned MAX_ERRORS = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [7:0]                block_length,
    input  logic [7:0]                generator,
    input  logic [7:0]                first_root,
    input  logic [8:0]                irreducible,
    input  logic                      in_valid,
    input  logic [7:0]                in_data,
    output logic                      in_ready,
    output logic                      busy,
    output logic                      done,
    output logic [8*2*MAX_ERRORS-1:0] syndromes,
    output logic                      all_zero
);

    localparam int unsigned NSYM = 2 * MAX_ERRORS;
    localparam int unsigned JW   = (NSYM > 1) ? $clog2(NSYM) : 1;

    localparam logic [JW-1:0] JLast = JW'(NSYM - 1);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StInit   = 3'd1;
    localparam logic [2:0] StAccept = 3'd2;
    localparam logic [2:0] StUpdate = 3'd3;
    localparam logic [2:0] StDone   = 3'd4;

    // Shift-and-add GF(2^8) product; the running multiplicand is reduced by
    // the mask whenever a doubling carries out of bit 7.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b,
                                          input logic [7:0] mask);
        logic [7:0] acc;
        logic [7:0] sh;
        acc = 8'h00;
        sh  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                acc = acc ^ sh;
            end
            sh = sh[7] ? ({sh[6:0], 1'b0} ^ mask) : {sh[6:0], 1'b0};
        end
        return acc;
    endfunction

    logic [2:0]    state_q, state_d;
    logic [JW-1:0] j_q, j_d;
    logic [8:0]    remaining_q, remaining_d;
    logic [7:0]    gen_q, gen_d;
    logic [7:0]    first_q, first_d;
    logic [7:0]    poly_q, poly_d;
    logic [7:0]    byte_q, byte_d;
    logic          all_zero_q, all_zero_d;
    logic [7:0]    roots_q [NSYM];
    logic [7:0]    roots_d [NSYM];
    logic [7:0]    synd_q  [NSYM];
    logic [7:0]    synd_d  [NSYM];

    logic [JW-1:0] j_prev;
    logic [7:0]    mul_a, mul_b, mul_p;
    logic          any_nonzero;

    // Only the reduction mask is used; bit 8 is implied by the field size.
    logic unused_irr_msb;
    assign unused_irr_msb = irreducible[8];

    assign j_prev = j_q - JW'(1);

    // Operand select for the one shared multiplier: INIT chains the roots,
    // UPDATE performs the Horner step S_j * r_j.
    always_comb begin
        mul_a = synd_q[j_q];
        mul_b = roots_q[j_q];
        if (state_q == StInit) begin
            mul_a = roots_q[j_prev];
            mul_b = gen_q;
        end
    end

    assign mul_p = gf_mul(mul_a, mul_b, poly_q);

    always_comb begin
        state_d     = state_q;
        j_d         = j_q;
        remaining_d = remaining_q;
        gen_d       = gen_q;
        first_d     = first_q;
        poly_d      = poly_q;
        byte_d      = byte_q;
        all_zero_d  = all_zero_q;
        roots_d     = roots_q;
        synd_d      = synd_q;
        any_nonzero = 1'b0;

        case (state_q)
            StIdle: begin
                if (start) begin
                    gen_d       = generator;
                    first_d     = first_root;
                    poly_d      = irreducible[7:0];
                    remaining_d = (block_length == 8'd0) ? 9'd256 : {1'b0, block_length};
                    j_d         = '0;
                    all_zero_d  = 1'b0;
                    state_d     = StInit;
                end
            end

            StInit: begin
                roots_d[j_q] = (j_q == '0) ? first_q : mul_p;
                synd_d[j_q]  = 8'h00;
                if (j_q == JLast) begin
                    j_d     = '0;
                    state_d = StAccept;
                end else begin
                    j_d = j_q + JW'(1);
                end
            end

            StAccept: begin
                if (in_valid) begin
                    byte_d = in_data;
                    if (remaining_q != 9'd0) begin
                        remaining_d = remaining_q - 9'd1;
                    end
                    j_d     = '0;
                    state_d = StUpdate;
                end
            end

            StUpdate: begin
                synd_d[j_q] = mul_p ^ byte_q;
                if (j_q == JLast) begin
                    j_d = '0;
                    if (remaining_q == 9'd0) begin
                        // Flag is taken from the final values written this cycle.
                        for (int k = 0; k < NSYM; k++) begin
                            any_nonzero = any_nonzero | (synd_d[k] != 8'h00);
                        end
                        all_zero_d = ~any_nonzero;
                        state_d    = StDone;
                    end else begin
                        state_d = StAccept;
                    end
                end else begin
                    j_d = j_q + JW'(1);
                end
            end

            StDone: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            j_q         <= '0;
            remaining_q <= 9'd0;
            gen_q       <= 8'h00;
            first_q     <= 8'h00;
            poly_q      <= 8'h00;
            byte_q      <= 8'h00;
            all_zero_q  <= 1'b0;
            for (int k = 0; k < NSYM; k++) begin
                roots_q[k] <= 8'h00;
                synd_q[k]  <= 8'h00;
            end
        end else begin
            state_q     <= state_d;
            j_q         <= j_d;
            remaining_q <= remaining_d;
            gen_q       <= gen_d;
            first_q     <= first_d;
            poly_q      <= poly_d;
            byte_q      <= byte_d;
            all_zero_q  <= all_zero_d;
            for (int k = 0; k < NSYM; k++) begin
                roots_q[k] <= roots_d[k];
                synd_q[k]  <= synd_d[k];
            end
        end
    end

    always_comb begin
        syndromes = '0;
        for (int k = 0; k < NSYM; k++) begin
            syndromes[8*k +: 8] = synd_q[k];
        end
    end

    assign in_ready = (state_q == StAccept);
    assign busy     = (state_q != StIdle);
    assign done     = (state_q == StDone);
    assign all_zero = all_zero_q;

endmodule
